// File: rtl/rvvi_trace_pkg.sv
// Shared types for the RVVI retirement trace path: the event record carried from
// the DUT retire lanes to the tracer, plus its field widths.
package rvvi_trace_pkg;

  localparam int unsigned RVVI_HART_W  = 8;
  localparam int unsigned RVVI_ORDER_W = 64;
  localparam int unsigned RVVI_CYCLE_W = 64;
  localparam int unsigned RVVI_XLEN    = 64;
  localparam int unsigned RVVI_ILEN    = 32;

  typedef struct packed {
    logic [RVVI_ORDER_W-1:0] order;
    logic [RVVI_CYCLE_W-1:0] cycle;
    logic [RVVI_HART_W-1:0]  hart;
    logic                    trap;
    logic [RVVI_XLEN-1:0]    pc;
    logic [RVVI_ILEN-1:0]    insn;
    logic                    gpr_we;
    logic [4:0]              gpr_idx;
    logic [RVVI_XLEN-1:0]    gpr_data;
  } rvvi_event_t;

endpackage

// File: rtl/rvvi_lane_compactor.sv
// Maps the per-lane valid mask to each lane's slot offset among the valid lanes
// (ascending lane order) and the total number of valid lanes.
module rvvi_lane_compactor #(
  parameter int unsigned NRET = 2,
  parameter int unsigned CntW = 4
) (
  input  logic [NRET-1:0]           in_valid,
  output logic [NRET-1:0][CntW-1:0] offset,
  output logic [CntW-1:0]           k
);

  logic [CntW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < NRET; i++) begin
      offset[i] = acc;
      acc       = acc + CntW'(in_valid[i]);
    end
    k = acc;
  end

endmodule

// File: rtl/rvvi_retire_queue.sv
// Serialises up to NRET retire/trap events per cycle into a single oldest-first
// stream, stamping order and cycle numbers and counting events the DUT forced us to drop.
module rvvi_retire_queue
  import rvvi_trace_pkg::*;
#(
  parameter int unsigned XLEN  = RVVI_XLEN,
  parameter int unsigned ILEN  = RVVI_ILEN,
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NRET-1:0]        in_valid,
  input  logic [NRET-1:0]        in_trap,
  input  logic [NRET*8-1:0]      in_hart,
  input  logic [NRET*XLEN-1:0]   in_pc,
  input  logic [NRET*ILEN-1:0]   in_insn,
  input  logic [NRET-1:0]        in_gpr_we,
  input  logic [NRET*5-1:0]      in_gpr_idx,
  input  logic [NRET*XLEN-1:0]   in_gpr_data,
  output logic                   in_ready,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output rvvi_event_t            ev_event,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [RVVI_ORDER_W-1:0]   order_q, order_d;
  logic [RVVI_CYCLE_W-1:0]   cycle_q;
  logic                      overflow_q, overflow_d;
  logic [15:0]               drop_q, drop_d;
  logic [16:0]               drop_sum;
  rvvi_event_t               mem_q [DEPTH];
  rvvi_event_t               lane_ev [NRET];
  logic [NRET-1:0][CntW-1:0] offset;
  logic [CntW-1:0]           k;
  logic                      push, pop, drop_hit;

  rvvi_lane_compactor #(
    .NRET (NRET),
    .CntW (CntW)
  ) u_compactor (
    .in_valid (in_valid),
    .offset   (offset),
    .k        (k)
  );

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      lane_ev[i].order    = order_q + RVVI_ORDER_W'(offset[i]);
      lane_ev[i].cycle    = cycle_q;
      lane_ev[i].hart     = in_hart[i*8 +: 8];
      lane_ev[i].trap     = in_trap[i];
      lane_ev[i].pc       = in_pc[i*XLEN +: XLEN];
      lane_ev[i].insn     = in_insn[i*ILEN +: ILEN];
      lane_ev[i].gpr_we   = in_gpr_we[i];
      lane_ev[i].gpr_idx  = in_gpr_idx[i*5 +: 5];
      lane_ev[i].gpr_data = in_gpr_data[i*XLEN +: XLEN];
    end
  end

  // Readiness comes from the registered count only, so a same-cycle pop never helps.
  assign in_ready = (CntW'(DEPTH) - count_q) >= CntW'(NRET);
  assign ev_valid = (count_q != '0);
  assign ev_event = ev_valid ? mem_q[rd_ptr_q] : '0;

  assign push     = in_ready && !flush;
  assign pop      = ev_valid && ev_ready && !flush;
  assign drop_hit = !in_ready && (k != '0) && !flush;
  assign drop_sum = {1'b0, drop_q} + 17'(k);

  always_comb begin
    count_d    = count_q + (push ? k : '0) - CntW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(k) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    // Every presented event consumes an order number, even when dropped or flushed.
    order_d    = order_q + RVVI_ORDER_W'(k);
    overflow_d = overflow_q | drop_hit;
    drop_d     = drop_q;
    if (drop_hit) drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      order_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      order_q    <= order_d;
      cycle_q    <= cycle_q + 1'b1;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (push && in_valid[i]) mem_q[wr_ptr_q + PtrW'(offset[i])] <= lane_ev[i];
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rvvi_retire_queue.sv
// Bench for rvvi_retire_queue: queue-based reference model checked every cycle,
// a table of overflow vectors, directed corner sequences and a randomized run.
module tb_rvvi_retire_queue;
  import rvvi_trace_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NRET-1:0]      in_valid = '0, in_trap = '0, in_gpr_we = '0;
  logic [NRET*8-1:0]    in_hart = '0;
  logic [NRET*XLEN-1:0] in_pc = '0, in_gpr_data = '0;
  logic [NRET*ILEN-1:0] in_insn = '0;
  logic [NRET*5-1:0]    in_gpr_idx = '0;
  logic                 ev_ready = 1'b0;
  logic                 in_ready, ev_valid, overflow;
  rvvi_event_t          ev_event;
  logic [15:0]          drop_count;

  rvvi_retire_queue #(
    .XLEN (XLEN), .ILEN (ILEN), .NRET (NRET), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_trap (in_trap), .in_hart (in_hart), .in_pc (in_pc),
    .in_insn (in_insn), .in_gpr_we (in_gpr_we), .in_gpr_idx (in_gpr_idx),
    .in_gpr_data (in_gpr_data), .in_ready (in_ready), .ev_valid (ev_valid),
    .ev_ready (ev_ready), .ev_event (ev_event), .overflow (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: an ideal FIFO of events plus the global counters.
  rvvi_event_t     mq[$];
  longint unsigned m_order, m_cycle;
  logic            m_ovf;
  int unsigned     m_drop;
  int              n_checks = 0, n_fail = 0;

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic        e_ovf;
    logic [15:0] e_drop;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rvvi_event_t mk_ev(input int i, input longint unsigned ord);
    rvvi_event_t e;
    e.order    = ord;
    e.cycle    = m_cycle;
    e.hart     = in_hart[i*8 +: 8];
    e.trap     = in_trap[i];
    e.pc       = in_pc[i*XLEN +: XLEN];
    e.insn     = in_insn[i*ILEN +: ILEN];
    e.gpr_we   = in_gpr_we[i];
    e.gpr_idx  = in_gpr_idx[i*5 +: 5];
    e.gpr_data = in_gpr_data[i*XLEN +: XLEN];
    return e;
  endfunction

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [31:0] insn,
                          input logic we, input logic [4:0] idx, input logic [63:0] data);
    in_pc[i*XLEN +: XLEN]       = pc;
    in_insn[i*ILEN +: ILEN]     = insn;
    in_gpr_we[i]                = we;
    in_gpr_idx[i*5 +: 5]        = idx;
    in_gpr_data[i*XLEN +: XLEN] = data;
    in_trap[i]                  = 1'b0;
    in_hart[i*8 +: 8]           = 8'h00;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < NRET; i++) begin
      in_pc[i*XLEN +: XLEN]       = {$urandom(), $urandom()};
      in_insn[i*ILEN +: ILEN]     = $urandom();
      in_gpr_we[i]                = 1'($urandom());
      in_gpr_idx[i*5 +: 5]        = 5'($urandom());
      in_gpr_data[i*XLEN +: XLEN] = {$urandom(), $urandom()};
      in_trap[i]                  = 1'($urandom());
      in_hart[i*8 +: 8]           = 8'($urandom());
    end
  endtask

  // One clock: called at a negedge, checks outputs against the model, advances both.
  task automatic step(input logic [NRET-1:0] v, input logic rdy, input logic fl);
    rvvi_event_t head;
    int          k, j;
    bit          room;
    in_valid = v;
    ev_ready = rdy;
    flush    = fl;
    #1;
    room = (int'(DEPTH) - mq.size()) >= int'(NRET);
    head = (mq.size() != 0) ? mq[0] : '0;
    chk("ev_valid", ev_valid, mq.size() != 0);
    chk("in_ready", in_ready, room);
    chk("ev_event", ev_event, head);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
    k = 0;
    for (int i = 0; i < NRET; i++) k += int'(v[i]);
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (room) begin
        j = 0;
        for (int i = 0; i < NRET; i++) begin
          if (v[i]) begin
            mq.push_back(mk_ev(i, m_order + longint'(j)));
            j++;
          end
        end
      end else if (k > 0) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
      end
    end
    m_order += longint'(k);
    m_cycle++;
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = '0;
    flush    = 1'b0;
    ev_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ev_event", ev_event, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    mq.delete();
    m_order = 0;
    m_cycle = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[5] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[6] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2};

    @(negedge clk);
    do_reset();

    // First event after three idle cycles.
    repeat (3) step(2'b00, 1'b0, 1'b0);
    set_lane(0, 64'h8000_0000, 32'h0000_0013, 1'b1, 5'd1, 64'd5);
    set_lane(1, 64'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 5'd9, 64'd99);
    step(2'b01, 1'b0, 1'b0);
    chk("t1_valid", ev_valid, 1'b1);
    chk("t1_order", ev_event.order, 64'd0);
    chk("t1_cycle", ev_event.cycle, 64'd3);
    chk("t1_idx", ev_event.gpr_idx, 5'd1);
    chk("t1_data", ev_event.gpr_data, 64'd5);
    step(2'b00, 1'b1, 1'b0);

    // Lane compaction and oldest-first ordering.
    do_reset();
    set_lane(1, 64'h8000_0004, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
    step(2'b10, 1'b0, 1'b0);
    set_lane(0, 64'h8000_008C, 32'h0000_0013, 1'b1, 5'd2, 64'd7);
    set_lane(1, 64'h8000_0090, 32'h0000_0013, 1'b1, 5'd3, 64'd8);
    step(2'b11, 1'b0, 1'b0);
    chk("t2_pc0", ev_event.pc, 64'h8000_0004);
    chk("t2_ord0", ev_event.order, 64'd0);
    step(2'b00, 1'b1, 1'b0);
    chk("t2_pc1", ev_event.pc, 64'h8000_008C);
    chk("t2_ord1", ev_event.order, 64'd1);
    step(2'b00, 1'b1, 1'b0);
    chk("t2_pc2", ev_event.pc, 64'h8000_0090);
    chk("t2_ord2", ev_event.order, 64'd2);
    step(2'b00, 1'b1, 1'b0);

    // Fill, overflow and partial drain from the vector table.
    do_reset();
    foreach (tbl[r]) begin
      rand_lanes();
      step(tbl[r].v, tbl[r].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", r), ev_valid, tbl[r].e_valid);
      chk($sformatf("tbl%0d_ready", r), in_ready, tbl[r].e_ready);
      chk($sformatf("tbl%0d_ovf", r), overflow, tbl[r].e_ovf);
      chk($sformatf("tbl%0d_drop", r), drop_count, tbl[r].e_drop);
    end
    repeat (6) step(2'b00, 1'b1, 1'b0);
    rand_lanes();
    step(2'b01, 1'b0, 1'b0);
    chk("gap_order", ev_event.order, 64'd10);

    // Near-full with a same-cycle pop: push is refused, FIFO order kept across wrap.
    repeat (3) begin
      rand_lanes();
      step(2'b11, 1'b0, 1'b0);
    end
    chk("full7_ready", in_ready, 1'b0);
    rand_lanes();
    step(2'b01, 1'b1, 1'b0);
    chk("full7_drop", drop_count, 16'd3);
    repeat (4) begin
      rand_lanes();
      step(2'b01, 1'b1, 1'b0);
    end
    repeat (8) step(2'b00, 1'b1, 1'b0);

    // Head holds under backpressure; flush empties the queue.
    do_reset();
    rand_lanes();
    step(2'b11, 1'b0, 1'b0);
    rand_lanes();
    step(2'b01, 1'b0, 1'b0);
    begin
      rvvi_event_t hd;
      hd = mq[0];
      for (int c = 0; c < 5; c++) begin
        rand_lanes();
        step(2'b00, 1'b0, 1'b0);
        chk($sformatf("hold%0d", c), ev_event, hd);
      end
    end
    rand_lanes();
    step(2'b11, 1'b1, 1'b1);
    chk("flush_valid", ev_valid, 1'b0);

    // Reset in the middle of a burst.
    rand_lanes();
    step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    do_reset();
    rand_lanes();
    step(2'b01, 1'b0, 1'b0);
    chk("rst2_order", ev_event.order, 64'd0);
    chk("rst2_cycle", ev_event.cycle, 64'd0);

    // Randomized traffic with phases of heavy backpressure.
    for (int n = 0; n < 600; n++) begin
      logic rdy;
      rand_lanes();
      rdy = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(NRET'($urandom()), rdy, $urandom_range(0, 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
